// File: rtl/uart_tx_frame.sv
// UART serial transmitter: start, DATA_BITS data LSB-first, optional parity, STOP_BITS stop bits.
// Parity bit is present only when UART_TX_PARITY_EN is defined; default build has no parity.
module uart_tx_frame #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    // Elaboration-time guard against illegal parameter combinations.
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_frame: CLK_FREQ_HZ/BAUD_RATE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t               state, state_nx;
    logic [BAUD_W-1:0]    baud_cnt, baud_nx;
    logic [BIT_W-1:0]     bit_cnt, bit_nx;
    logic [DATA_BITS-1:0] shift_reg, shift_nx;
    logic                 tx_nx;
    logic                 bit_end;

`ifdef UART_TX_PARITY_EN
    // Parity comes from a copy of the accepted word, since shift_reg is consumed during DATA.
    logic [DATA_BITS-1:0] data_q, data_nx;
    logic                 par_bit;

    assign par_bit = (^data_q) ^ 1'(PARITY_ODD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_nx;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_nx;
            baud_cnt  <= baud_nx;
            bit_cnt   <= bit_nx;
            shift_reg <= shift_nx;
            tx        <= tx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt;
        bit_nx   = bit_cnt;
        shift_nx = shift_reg;
        done     = 1'b0;
        bit_end  = (baud_cnt == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
        data_nx  = data_q;
`endif

        if (state != S_IDLE) begin
            baud_nx = bit_end ? '0 : baud_cnt + 1'b1;
        end

        unique case (state)
            S_IDLE: begin
                if (valid) begin
                    state_nx = S_START;
                    baud_nx  = '0;
                    shift_nx = data_in;
`ifdef UART_TX_PARITY_EN
                    data_nx  = data_in;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nx = S_DATA;
                    bit_nx   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_nx = shift_reg >> 1;
                    if (bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_nx = S_PARITY;
`else
                        state_nx = S_STOP;
`endif
                        bit_nx   = '0;
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_nx = S_STOP;
                    bit_nx   = '0;
                end
            end
`endif
            S_STOP: begin
                // bit_cnt counts stop bits here; done marks the final cycle of the frame.
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_nx = S_IDLE;
                        done     = 1'b1;
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // tx is registered from the next state so the start bit begins on the accepting edge.
    always_comb begin
        tx_nx = 1'b1;
        unique case (state_nx)
            S_START:  tx_nx = 1'b0;
            S_DATA:   tx_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_nx = par_bit;
`endif
            default:  tx_nx = 1'b1;
        endcase
    end

    assign ready = (state == S_IDLE);
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: an 8N1 (even) and a 7N2 (odd) instance at 4 clocks/bit,
// checked cycle by cycle against a bit-list model of each frame.
module tb_uart_tx_frame;

    localparam int CLK_HZ = 38400;
    localparam int BAUD   = 9600;
    localparam int CPB    = CLK_HZ / BAUD;

`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] d8 = '0;
    logic       v8 = 1'b0;
    logic       r8, t8, b8, dn8;
    logic [6:0] d7 = '0;
    logic       v7 = 1'b0;
    logic       r7, t7, b7, dn7;

    uart_tx_frame #(
        .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
    ) u8 (
        .clk(clk), .rst_n(rst_n), .data_in(d8), .valid(v8),
        .ready(r8), .tx(t8), .busy(b8), .done(dn8)
    );

    uart_tx_frame #(
        .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)
    ) u7 (
        .clk(clk), .rst_n(rst_n), .data_in(d7), .valid(v7),
        .ready(r7), .tx(t7), .busy(b7), .done(dn7)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_bits[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line bits of one frame: start, data LSB-first, optional parity, stop bits.
    task automatic build_frame(input int sel, input logic [8:0] word);
        int db;
        int sb;
        bit podd;
        bit ones;
        db   = (sel == 1) ? 7 : 8;
        sb   = (sel == 1) ? 2 : 1;
        podd = (sel == 1);
        ones = 1'b0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < db; i++) begin
            exp_bits.push_back(word[i]);
            ones ^= word[i];
        end
        if (PBITS == 1) exp_bits.push_back(ones ^ podd);
        for (int i = 0; i < sb; i++) exp_bits.push_back(1'b1);
    endtask

    task automatic drive(input int sel, input logic v, input logic [8:0] w);
        if (sel == 1) begin
            v7 = v;
            d7 = w[6:0];
        end else begin
            v8 = v;
            d8 = w[7:0];
        end
    endtask

    task automatic sample(input int sel, output logic t, output logic r, output logic b, output logic d);
        if (sel == 1) begin
            t = t7; r = r7; b = b7; d = dn7;
        end else begin
            t = t8; r = r8; b = b8; d = dn8;
        end
    endtask

    task automatic check_idle(input int sel, input string where);
        logic t, r, b, d;
        sample(sel, t, r, b, d);
        chk($sformatf("%s u%0d tx", where, sel == 1 ? 7 : 8), t, 1);
        chk($sformatf("%s u%0d ready", where, sel == 1 ? 7 : 8), r, 1);
        chk($sformatf("%s u%0d busy", where, sel == 1 ? 7 : 8), b, 0);
        chk($sformatf("%s u%0d done", where, sel == 1 ? 7 : 8), d, 0);
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling edge of the idle cycle after.
    task automatic run_frame(input int sel, input logic [8:0] word, input bit hold, input int inject_at);
        int len;
        logic t, r, b, d;
        string nm;
        build_frame(sel, word);
        len = exp_bits.size() * CPB;
        drive(sel, 1'b1, word);
        @(negedge clk);
        if (!hold) drive(sel, 1'b0, 9'($urandom));
        for (int c = 1; c <= len; c++) begin
            sample(sel, t, r, b, d);
            nm = $sformatf("u%0d w=%0h c=%0d", sel == 1 ? 7 : 8, word, c);
            chk({nm, " tx"}, t, exp_bits[(c - 1) / CPB]);
            chk({nm, " ready"}, r, 0);
            chk({nm, " busy"}, b, 1);
            chk({nm, " done"}, d, (c == len));
            if (inject_at > 0 && c == inject_at) drive(sel, 1'b1, 9'h1FF);
            if (inject_at > 0 && c == inject_at + 2) drive(sel, 1'b0, 9'h1FF);
            @(negedge clk);
        end
        check_idle(sel, $sformatf("after w=%0h", word));
    endtask

    initial begin
        bit hold;
        int inj;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle(0, "reset");
        check_idle(1, "reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(0, 9'h0A5, 1'b0, 0);
        run_frame(1, 9'h055, 1'b0, 0);
        run_frame(0, 9'h001, 1'b1, 0);
        run_frame(0, 9'h080, 1'b0, 0);
        run_frame(0, 9'h03C, 1'b0, 10);
        run_frame(1, 9'h012, 1'b0, 17);
        repeat (3) @(negedge clk);

        // Reset during cycle 17 of an 8N1 frame.
        drive(0, 1'b1, 9'h0A5);
        @(negedge clk);
        drive(0, 1'b0, 9'h000);
        repeat (16) @(negedge clk);
        chk("pre-reset busy", b8, 1);
        rst_n = 1'b0;
        #1;
        check_idle(0, "mid-frame reset");
        @(negedge clk);
        check_idle(0, "reset held");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(0, "reset released");
        run_frame(0, 9'h0C3, 1'b0, 0);

        for (int sel = 0; sel < 2; sel++) begin
            for (int i = 0; i < 12; i++) begin
                hold = (i != 11) && ($urandom_range(0, 1) == 1);
                inj  = (!hold && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0;
                run_frame(sel, 9'($urandom), hold, inj);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
